// File: rtl/usb_rx_reader.sv
// FT60x 245-sync-FIFO read master: drives usb_oe/usb_rd and buffers {be,data} words into a FWFT fifo.
// Latency 1 (captured at edge N, visible after N); rx_ready low stalls output, reading pauses at free <= RESERVE.

module fifo #(
  parameter int WIDTH  = 36,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              push,
  input  logic [WIDTH-1:0]  din,
  input  logic              pop,
  output logic [WIDTH-1:0]  dout,
  output logic [ADDR_W:0]   count,
  output logic              drop
);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic              full;
  logic              do_push;
  logic              do_pop;

  // A pop frees the slot in the same cycle, so a full buffer still accepts push+pop.
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign dout    = mem[rptr];

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

module usb_rx_reader #(
  parameter int DEPTH   = 16,
  parameter int RESERVE = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        usb_rxf,
  input  logic [31:0] usb_data_in,
  input  logic [3:0]  usb_be_in,
  output logic        usb_oe,
  output logic        usb_rd,
  input  logic        rx_ready,
  output logic        rx_valid,
  output logic [31:0] rx_data,
  output logic [3:0]  rx_be,
  output logic        overflow,
  output logic [31:0] word_count
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
  // free > RESERVE  <=>  count < DEPTH-RESERVE
  localparam logic [ADDR_W:0] START_MAX = (ADDR_W+1)'(DEPTH - RESERVE);

  // State bits are {oe, rd, hold} so the strobes come straight off flops.
  typedef enum logic [2:0] {
    IDLE = 3'b000,
    TURN = 3'b100,
    READ = 3'b110,
    HOLD = 3'b101
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            capture;
  logic            pop;
  logic            drop;
  logic [ADDR_W:0] count;
  logic [ADDR_W:0] count_after;
  logic [35:0]     head_dat;

  assign capture  = ((state == READ) || (state == HOLD)) && usb_rxf;
  assign rx_valid = (count != '0);
  assign pop      = rx_valid && rx_ready;
  assign {rx_be, rx_data} = head_dat;

  fifo #(.WIDTH(36), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_buf (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (capture),
    .din    ({usb_be_in, usb_data_in}),
    .pop    (pop),
    .dout   (head_dat),
    .count  (count),
    .drop   (drop)
  );

  always_comb begin
    count_after = count;
    if (capture && !drop) count_after = count_after + CNT_ONE;
    if (pop)              count_after = count_after - CNT_ONE;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (usb_rxf && (count < START_MAX)) state_nxt = TURN;
      TURN:    state_nxt = usb_rxf ? READ : IDLE;
      READ: begin
        if (!usb_rxf)                    state_nxt = IDLE;
        else if (count_after >= START_MAX) state_nxt = HOLD;
      end
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    usb_oe = state[2];
    usb_rd = state[1];
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      if (drop)    overflow   <= 1'b1;
      if (capture) word_count <= word_count + 32'd1;
    end
  end
endmodule
